// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM port arbiter.
// FSM state encoding and round-robin grant class live here.
package sdram_arb_pkg;

   localparam int unsigned SDRAM_ADDR_W_DEF = 26;
   localparam int unsigned SDRAM_DATA_W_DEF = 32;
   localparam int unsigned SDRAM_TMO_DEF    = 64;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_RD_DONE  = 3'd3,
      S_WR_ISSUE = 3'd4
   } arb_state_e;

   typedef enum logic {
      GNT_READ  = 1'b0,
      GNT_WRITE = 1'b1
   } grant_e;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Two-client (read/write) SDRAM port arbiter with round-robin
// grant on conflict, bounded read wait and registered outputs.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = SDRAM_ADDR_W_DEF,
   parameter int unsigned DATA_W         = SDRAM_DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = SDRAM_TMO_DEF
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              enable,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              sdram_read_en,
   output logic              sdram_write_en,
   output logic [ADDR_W-1:0] address_sdram,
   output logic [DATA_W-1:0] writeData_sdram,
   input  logic [DATA_W-1:0] data_sdram,
   input  logic              sdram_datareadvalid,
   output logic              busy,
   output logic              timeout_flag
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

   arb_state_e        state_q, state_d;
   grant_e            lg_q, lg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              rd_en_q, rd_en_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_ack_q, rd_ack_d;
   logic              rd_err_q, rd_err_d;
   logic              wr_ack_q, wr_ack_d;
   logic              busy_q, busy_d;
   logic              tflag_q, tflag_d;
   logic              pick_rd;

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Read wins when it is alone or when write was served last.
   assign pick_rd = rd_req && (!wr_req || (lg_q == GNT_WRITE));

   // Next-state and registered-output logic; outputs track state_d.
   always_comb begin
      state_d  = state_q;
      lg_d     = lg_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      tflag_d  = tflag_q;
      rd_en_d  = 1'b0;
      wr_en_d  = 1'b0;
      rd_ack_d = 1'b0;
      rd_err_d = 1'b0;
      wr_ack_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable && pick_rd) begin
               state_d = S_RD_ISSUE;
               addr_d  = rd_addr;
               rd_en_d = 1'b1;
            end else if (enable && wr_req) begin
               state_d  = S_WR_ISSUE;
               addr_d   = wr_addr;
               wdata_d  = wr_data;
               wr_en_d  = 1'b1;
               wr_ack_d = 1'b1;
            end
         end
         S_RD_ISSUE: begin
            state_d = S_RD_WAIT;
            cnt_d   = '0;
         end
         S_RD_WAIT: begin
            cnt_d = cnt_inc;
            if (sdram_datareadvalid) begin
               state_d  = S_RD_DONE;
               rdata_d  = data_sdram;
               rd_ack_d = 1'b1;
            end else if (cnt_inc == CNT_LIM) begin
               state_d  = S_RD_DONE;
               rd_ack_d = 1'b1;
               rd_err_d = 1'b1;
               tflag_d  = 1'b1;
            end
         end
         S_RD_DONE: begin
            state_d = S_IDLE;
            lg_d    = GNT_READ;
         end
         S_WR_ISSUE: begin
            state_d = S_IDLE;
            lg_d    = GNT_WRITE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset abandons any transaction.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         lg_q     <= GNT_WRITE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         cnt_q    <= '0;
         tflag_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
         wr_ack_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lg_q     <= lg_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
         tflag_q  <= tflag_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
         rd_ack_q <= rd_ack_d;
         rd_err_q <= rd_err_d;
         wr_ack_q <= wr_ack_d;
         busy_q   <= busy_d;
      end
   end

   assign sdram_read_en   = rd_en_q;
   assign sdram_write_en  = wr_en_q;
   assign address_sdram   = addr_q;
   assign writeData_sdram = wdata_q;
   assign rd_data         = rdata_q;
   assign rd_ack          = rd_ack_q;
   assign rd_err          = rd_err_q;
   assign wr_ack          = wr_ack_q;
   assign busy            = busy_q;
   assign timeout_flag    = tflag_q;

endmodule
